// File: rtl/obstacle_spawner.sv
// obstacle_spawner: paces obstacle spawns in video frames, draws start X and type from a
// free-running Galois LFSR, offers each spawn on valid/ready and ramps difficulty by level.
module obstacle_spawner #(
    parameter int unsigned X_MAX          = 608,
    parameter int unsigned START_Y        = 0,
    parameter int unsigned PERIOD_INIT    = 120,
    parameter int unsigned PERIOD_MIN     = 30,
    parameter int unsigned PERIOD_STEP    = 10,
    parameter int unsigned SPAWNS_PER_LVL = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_frame_tick,
    input  logic        i_enable,
    input  logic        i_spawn_ready,
    output logic        o_spawn_valid,
    output logic [1:0]  o_obstacle_trigger,
    output logic [9:0]  o_obstacle_start_x,
    output logic [9:0]  o_obstacle_start_y,
    output logic [3:0]  o_level,
    output logic [15:0] o_spawn_count
);

    localparam logic [9:0]  C_X_MAX     = 10'(X_MAX);
    localparam logic [9:0]  C_X_WRAP    = 10'(X_MAX + 1);
    localparam logic [9:0]  C_START_Y   = 10'(START_Y);
    localparam logic [7:0]  C_P_INIT    = 8'(PERIOD_INIT);
    localparam logic [7:0]  C_P_MIN     = 8'(PERIOD_MIN);
    localparam logic [7:0]  C_P_STEP    = 8'(PERIOD_STEP);
    localparam logic [7:0]  C_P_FLOOR   = 8'(PERIOD_MIN + PERIOD_STEP);
    localparam logic [3:0]  C_LVL_LAST  = 4'(SPAWNS_PER_LVL - 1);
    localparam logic [3:0]  C_LEVEL_MAX = 4'd15;
    localparam logic [15:0] C_LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SPAWN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_lfsr;
    logic [7:0]  r_period;
    logic [7:0]  w_period_nxt;
    logic [7:0]  r_countdown;
    logic [7:0]  w_countdown_nxt;
    logic [3:0]  r_lvl_cnt;
    logic [3:0]  w_lvl_cnt_nxt;
    logic [3:0]  r_level;
    logic [3:0]  w_level_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [1:0]  r_trigger;
    logic [1:0]  w_trigger_nxt;
    logic [9:0]  r_x;
    logic [9:0]  w_x_nxt;
    logic [9:0]  r_y;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        lfsr_step = l[0] ? ((l >> 1) ^ C_LFSR_MASK) : (l >> 1);
    endfunction

    // Fold the 10-bit draw into 0..X_MAX; a single subtraction suffices since 1023 < 2*(X_MAX+1).
    function automatic logic [9:0] map_x(input logic [9:0] r);
        map_x = (r > C_X_MAX) ? (r - C_X_WRAP) : r;
    endfunction

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath values
    always_comb begin
        w_state_nxt     = r_state;
        w_period_nxt    = r_period;
        w_countdown_nxt = r_countdown;
        w_lvl_cnt_nxt   = r_lvl_cnt;
        w_level_nxt     = r_level;
        w_count_nxt     = r_count;
        w_valid_nxt     = r_valid;
        w_trigger_nxt   = r_trigger;
        w_x_nxt         = r_x;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_countdown_nxt = r_period;
                    w_state_nxt     = ST_COUNT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_frame_tick) begin
                    if (r_countdown <= 8'd1) begin
                        w_countdown_nxt = 8'd0;
                        w_valid_nxt     = 1'b1;
                        w_x_nxt         = map_x(r_lfsr[9:0]);
                        w_trigger_nxt   = r_lfsr[11:10];
                        w_state_nxt     = ST_SPAWN;
                    end else begin
                        w_countdown_nxt = r_countdown - 8'd1;
                    end
                end else begin
                    w_countdown_nxt = r_countdown;
                end
            end
            ST_SPAWN: begin
                // An accept wins over a simultaneous disable: the consumer already took it.
                if (r_valid && i_spawn_ready) begin
                    w_valid_nxt = 1'b0;
                    w_count_nxt = r_count + 16'd1;
                    w_state_nxt = i_enable ? ST_COUNT : ST_IDLE;
                    if (r_lvl_cnt >= C_LVL_LAST) begin
                        w_lvl_cnt_nxt   = 4'd0;
                        w_level_nxt     = (r_level == C_LEVEL_MAX) ? r_level : (r_level + 4'd1);
                        w_period_nxt    = (r_period >= C_P_FLOOR) ? (r_period - C_P_STEP) : C_P_MIN;
                        w_countdown_nxt = w_period_nxt;
                    end else begin
                        w_lvl_cnt_nxt   = r_lvl_cnt + 4'd1;
                        w_countdown_nxt = r_period;
                    end
                end else if (!i_enable) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SPAWN;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; the LFSR free-runs every cycle regardless of state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr      <= LFSR_SEED;
            r_period    <= C_P_INIT;
            r_countdown <= C_P_INIT;
            r_lvl_cnt   <= 4'd0;
            r_level     <= 4'd0;
            r_count     <= 16'd0;
            r_valid     <= 1'b0;
            r_trigger   <= 2'd0;
            r_x         <= 10'd0;
            r_y         <= C_START_Y;
        end else begin
            r_lfsr      <= lfsr_step(r_lfsr);
            r_period    <= w_period_nxt;
            r_countdown <= w_countdown_nxt;
            r_lvl_cnt   <= w_lvl_cnt_nxt;
            r_level     <= w_level_nxt;
            r_count     <= w_count_nxt;
            r_valid     <= w_valid_nxt;
            r_trigger   <= w_trigger_nxt;
            r_x         <= w_x_nxt;
            r_y         <= C_START_Y;
        end
    end

    assign o_spawn_valid      = r_valid;
    assign o_obstacle_trigger = r_trigger;
    assign o_obstacle_start_x = r_x;
    assign o_obstacle_start_y = r_y;
    assign o_level            = r_level;
    assign o_spawn_count      = r_count;

endmodule
